sisc_ctrl: RTL and testbench
============================

Name: sisc_ctrl

Overview:
- Multicycle control unit of the SISC processor.
- Sequences each instruction through fetch, decode, execute, mem and writeback.
- Drives the register-file write enable, ALU op, writeback mux, branch-address select, PC controls and IR load.
- Decodes opcode ir[31:28] and condition/function field ir[27:24] against the 4-bit status register.

Parameters:
- none (opcode and state encodings are package constants)

Ports:
- clk  in  1  system clock, rising edge
- rst_f  in  1  reset, asynchronous, active-low
- opcode  in  4  instruction bits [31:28]
- mm  in  4  instruction bits [27:24]; branch condition mask
- stat  in  4  status register {C,N,V,Z}
- rf_we  out  1  register file write enable
- alu_op  out  4  ALU operation control
- wb_sel  out  1  writeback mux select; 0 = ALU result, 1 = memory data
- br_sel  out  1  branch address mode; 1 = absolute (imm), 0 = relative (pc+imm)
- pc_rst  out  1  PC reset, active-high
- pc_write  out  1  PC load enable
- pc_sel  out  1  PC source; 0 = pc+1, 1 = br_addr
- ir_load  out  1  IR load enable

Behaviour:
- Opcodes: NOOP=0, REG_OP=1, REG_IM=2, BRA=4, BRR=5, BNE=6, BNR=7, HLT=F. All other opcodes behave as NOOP.
- States: START0 → START1 → FETCH → DECODE → EXECUTE → MEM → WRITEBACK → FETCH. HALT is terminal.
- State register updates on rising clk. rst_f low forces START0 immediately, asynchronously, including mid-instruction.
- All outputs are combinational from state and opcode/mm/stat. Defaults are 0 unless listed below.
- START0: pc_rst=1. START1: all outputs 0.
- FETCH: ir_load=1, pc_write=1, pc_sel=0 (PC advances to pc+1 at the same edge the IR loads).
- DECODE:
  - BRA, BRR: taken when (mm & stat) != 0.
  - BNE, BNR: taken when (mm & stat) == 0.
  - If taken: pc_write=1, pc_sel=1. br_sel=1 for BRA/BNE, 0 for BRR/BNR.
  - br_sel reflects the opcode in DECODE whether or not the branch is taken.
  - mm=0 means BRA/BRR are never taken and BNE/BNR are always taken.
- EXECUTE and MEM:
  - REG_OP: alu_op=4'b0001 (function from ir[27:24]).
  - REG_IM: alu_op=4'b0011 (immediate operand).
  - Everything else: alu_op=4'b0000.
- WRITEBACK: REG_OP and REG_IM keep their alu_op, with rf_we=1 and wb_sel=0.
- HLT: in EXECUTE, next state is HALT. HALT drives all outputs 0 and persists until rst_f is asserted.
- A taken branch does not write the register file. rf_we is 1 only in WRITEBACK.
- Reset values: state=START0, pc_rst=1, every other output 0.

Optional Feature:
- Macro CTRL_TRACE_EN.
- When defined: simulation-only $display of state, opcode and mm on each state transition, plus a message when HALT is entered.
- When undefined: no simulation-only code, identical synthesized logic.

Decomposition:
- Package sisc_pkg holds:
  - opcode constants;
  - state enum typedef;
  - alu_op encodings (ALU_NONE=0000, ALU_REG=0001, ALU_IMM=0011);
  - stat bit indices.
- Natural sub-module: sisc_br_cond, combinational branch-taken evaluator (opcode, mm, stat → taken, br_sel).

Test Plan:
- Reset: rst_f low mid-EXECUTE → state START0 immediately, pc_rst=1, rf_we=0. Release → START1, then FETCH with ir_load=1, pc_write=1, pc_sel=0.
- REG_OP opcode=1, mm=2 → alu_op=0001 in EXECUTE, MEM and WRITEBACK; rf_we=1 and wb_sel=0 only in WRITEBACK; back to FETCH.
- REG_IM opcode=2 → alu_op=0011 in EXECUTE, MEM and WRITEBACK; rf_we=1 in WRITEBACK only.
- BRA opcode=4, mm=0001, stat=0001 → DECODE: pc_write=1, pc_sel=1, br_sel=1. With stat=0000 → pc_write=0.
- BNR opcode=7, mm=0100, stat=0000 → DECODE: pc_write=1, pc_sel=1, br_sel=0. With stat=0100 → not taken. No rf_we anywhere in the instruction.
- HLT opcode=F → EXECUTE, then HALT. Outputs stay 0 for 10+ cycles; rst_f pulse restarts at START0.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC multicycle control unit.
// Holds opcode values, the control state enum, ALU op encodings and the
// bit positions of the {C,N,V,Z} status register.
package sisc_pkg;

  // Opcodes carried in ir[31:28]; anything not listed here behaves as NOOP
  localparam logic [3:0] OP_NOOP   = 4'h0;
  localparam logic [3:0] OP_REG_OP = 4'h1;
  localparam logic [3:0] OP_REG_IM = 4'h2;
  localparam logic [3:0] OP_BRA    = 4'h4;
  localparam logic [3:0] OP_BRR    = 4'h5;
  localparam logic [3:0] OP_BNE    = 4'h6;
  localparam logic [3:0] OP_BNR    = 4'h7;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU operation encodings driven on alu_op
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_REG  = 4'b0001;
  localparam logic [3:0] ALU_IMM  = 4'b0011;

  // Bit positions inside the status register {C,N,V,Z}
  localparam int STAT_Z = 0;
  localparam int STAT_V = 1;
  localparam int STAT_N = 2;
  localparam int STAT_C = 3;

  // Control sequencer states
  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_e;

  // ALU op selected for an instruction while it executes
  function automatic logic [3:0] alu_op_for(input logic [3:0] op);
    case (op)
      OP_REG_OP: alu_op_for = ALU_REG;
      OP_REG_IM: alu_op_for = ALU_IMM;
      default:   alu_op_for = ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Combinational branch evaluator for the SISC control unit.
// Decides whether a branch opcode is taken from the condition mask and
// the status flags, and reports whether the branch target is absolute.
module sisc_br_cond
  import sisc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       taken,
  output logic       br_sel
);

  logic hit;

  // A branch condition matches when any masked status flag is set
  always_comb begin
    hit = (mm[STAT_Z] & stat[STAT_Z]) |
          (mm[STAT_V] & stat[STAT_V]) |
          (mm[STAT_N] & stat[STAT_N]) |
          (mm[STAT_C] & stat[STAT_C]);
  end

  // BRA/BRR branch on a match, BNE/BNR on no match; BRA/BNE use absolute targets
  always_comb begin
    taken  = 1'b0;
    br_sel = 1'b0;
    case (opcode)
      OP_BRA: begin taken = hit;  br_sel = 1'b1; end
      OP_BRR: begin taken = hit;  br_sel = 1'b0; end
      OP_BNE: begin taken = !hit; br_sel = 1'b1; end
      OP_BNR: begin taken = !hit; br_sel = 1'b0; end
      default: begin taken = 1'b0; br_sel = 1'b0; end
    endcase
  end

endmodule

// File: rtl/sisc_ctrl.sv
// Multicycle control unit of the SISC processor.
// Steps every instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK
// and drives the datapath controls combinationally from the current state.
// Define CTRL_TRACE_EN to print a simulation trace of state transitions.
module sisc_ctrl
  import sisc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_f,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       rf_we,
  output logic [3:0] alu_op,
  output logic       wb_sel,
  output logic       br_sel,
  output logic       pc_rst,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       ir_load
);

  state_e state_q, state_d;
  logic   br_taken;
  logic   br_abs;

  sisc_br_cond u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat),
    .taken  (br_taken),
    .br_sel (br_abs)
  );

  // State register; reset drops back to START0 at once, even mid-instruction
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state_q <= S_START0;
    else        state_q <= state_d;
  end

  // Next-state sequencing; HLT diverts to HALT after EXECUTE and stays there
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = (opcode == OP_HLT) ? S_HALT : S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START0;
    endcase
  end

  // Datapath controls decoded from state, opcode and branch outcome
  always_comb begin
    rf_we    = 1'b0;
    alu_op   = ALU_NONE;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    ir_load  = 1'b0;
    case (state_q)
      S_START0: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        pc_sel   = 1'b0;
      end
      S_DECODE: begin
        br_sel = br_abs;
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
        end
      end
      S_EXECUTE, S_MEM: alu_op = alu_op_for(opcode);
      S_WRITEBACK: begin
        alu_op = alu_op_for(opcode);
        if ((opcode == OP_REG_OP) || (opcode == OP_REG_IM)) begin
          rf_we  = 1'b1;
          wb_sel = 1'b0;
        end
      end
      default: ;
    endcase
  end

`ifdef CTRL_TRACE_EN
  // Simulation trace of every state change and of entry into HALT
  always @(posedge clk) begin
    if (rst_f && (state_d != state_q)) begin
      $display("[sisc_ctrl] %s -> %s opcode=%h mm=%b", state_q.name(), state_d.name(), opcode, mm);
      if (state_d == S_HALT)
        $display("[sisc_ctrl] HALT entered");
    end
  end
`endif

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: directed instructions from the test
// plan followed by random ones, compared each cycle against a phase model.
module tb_sisc_ctrl;

  logic       clk = 1'b0;
  logic       rst_f;
  logic [3:0] opcode, mm, stat;
  logic       rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load;
  logic [3:0] alu_op;

  int testsRun = 0;
  int testsFailed = 0;

  // Model phases of one instruction's life
  localparam int P_START0 = 0, P_START1 = 1, P_FETCH = 2, P_DECODE = 3;
  localparam int P_EXEC = 4, P_MEM = 5, P_WB = 6, P_HALT = 7;

  typedef struct { logic [3:0] op; logic [3:0] m; logic [3:0] st; } instr_t;
  instr_t directed[$];

  int phase;
  int instrCount = 0;
  int haltCycles = 0;
  bit midResetDone = 0;

  sisc_ctrl dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .br_sel(br_sel),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  function automatic logic [10:0] dutOut();
    return {rf_we, alu_op, wb_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load};
  endfunction

  // Expected control vector for a phase, written from the instruction rules
  function automatic logic [10:0] expected(input int ph, input logic [3:0] op,
                                           input logic [3:0] m, input logic [3:0] st);
    logic rfWe, wbSel, brSel, pcRst, pcWrite, pcSel, irLoad, taken;
    logic [3:0] alu;
    rfWe = 0; wbSel = 0; brSel = 0; pcRst = 0; pcWrite = 0; pcSel = 0; irLoad = 0;
    alu = 4'd0; taken = 0;
    if (ph == P_START0) pcRst = 1;
    if (ph == P_FETCH) begin irLoad = 1; pcWrite = 1; end
    if (ph == P_DECODE) begin
      if (op == 4'h4 || op == 4'h5) taken = ((m & st) != 4'd0);
      if (op == 4'h6 || op == 4'h7) taken = ((m & st) == 4'd0);
      brSel = (op == 4'h4 || op == 4'h6);
      if (taken) begin pcWrite = 1; pcSel = 1; end
    end
    if (ph == P_EXEC || ph == P_MEM || ph == P_WB) begin
      if (op == 4'h1) alu = 4'd1;
      if (op == 4'h2) alu = 4'd3;
    end
    if (ph == P_WB && (op == 4'h1 || op == 4'h2)) rfWe = 1;
    return {rfWe, alu, wbSel, brSel, pcRst, pcWrite, pcSel, irLoad};
  endfunction

  function automatic int nextPhase(input int ph, input logic [3:0] op);
    case (ph)
      P_EXEC:  return (op == 4'hF) ? P_HALT : P_MEM;
      P_WB:    return P_FETCH;
      P_HALT:  return P_HALT;
      default: return ph + 1;
    endcase
  endfunction

  // Count one comparison and report it if it differs
  task automatic checkOutput(input string tag, input logic [10:0] observed, input logic [10:0] expect_v);
    testsRun++;
    if (observed !== expect_v) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expect_v);
    end
  endtask

  // Present the next instruction: directed ones first, then random
  task automatic applyStimulus();
    instr_t ins;
    if (directed.size() > 0) ins = directed.pop_front();
    else begin
      ins.op = 4'($urandom_range(0, 15));
      ins.m  = 4'($urandom);
      ins.st = 4'($urandom);
    end
    opcode = ins.op; mm = ins.m; stat = ins.st;
    instrCount++;
  endtask

  // Pulse reset off-edge and check START0 is forced immediately
  task automatic pulseReset(input string tag);
    #2 rst_f = 1'b0;
    #1 checkOutput({tag, "_async"}, dutOut(), expected(P_START0, opcode, mm, stat));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_held"}, dutOut(), expected(P_START0, opcode, mm, stat));
    rst_f = 1'b1;
    phase = P_START0;
    haltCycles = 0;
  endtask

  initial begin
    directed.push_back('{4'h1, 4'h2, 4'h0});
    directed.push_back('{4'h2, 4'h5, 4'h3});
    directed.push_back('{4'h4, 4'h1, 4'h1});
    directed.push_back('{4'h4, 4'h1, 4'h0});
    directed.push_back('{4'h7, 4'h4, 4'h0});
    directed.push_back('{4'h7, 4'h4, 4'h4});
    directed.push_back('{4'h5, 4'h0, 4'hF});
    directed.push_back('{4'h6, 4'h0, 4'hF});
    directed.push_back('{4'h3, 4'hF, 4'hF});
    directed.push_back('{4'hF, 4'h0, 4'h0});

    opcode = 4'h0; mm = 4'h0; stat = 4'h0;
    rst_f = 1'b0;
    phase = P_START0;
    @(negedge clk);
    checkOutput("reset", dutOut(), expected(P_START0, opcode, mm, stat));
    rst_f = 1'b1;

    for (int cyc = 0; cyc < 3000 && instrCount < 80; cyc++) begin
      @(posedge clk);
      phase = nextPhase(phase, opcode);
      @(negedge clk);
      checkOutput($sformatf("ph%0d_op%h_mm%b_st%b", phase, opcode, mm, stat),
                  dutOut(), expected(phase, opcode, mm, stat));
      if (phase == P_HALT) begin
        haltCycles++;
        if (haltCycles >= 12) pulseReset("halt_reset");
      end else if (phase == P_EXEC && !midResetDone && instrCount >= 14) begin
        midResetDone = 1;
        pulseReset("mid_exec_reset");
      end else if (phase == P_START1 || phase == P_WB) begin
        applyStimulus();
      end
    end

    if (instrCount < 80)
      checkOutput("instr_budget", 11'(instrCount), 11'd80);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
